// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared types and 2-bit counter helper for branch_predict_unit
package bpu_pkg;

  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_t;

  // Write-port operation; the table does its own read-modify-write
  typedef enum logic [1:0] {
    WR_TAKEN     = 2'b00,
    WR_NOT_TAKEN = 2'b01,
    WR_INVAL     = 2'b10
  } wr_op_t;

  // Tag and target are held zero-extended to ADDR_W; unused upper bits stay 0
  typedef struct packed {
    logic              valid;
    logic              jmp;
    logic [ADDR_W-1:0] tag;
    logic [ADDR_W-1:0] target;
    cnt_t              cnt;
  } btb_entry_t;

  function automatic cnt_t sat_update(cnt_t cnt, logic taken);
    cnt_t nxt;
    if (taken) nxt = (cnt == ST)  ? ST  : cnt_t'(cnt + 2'd1);
    else       nxt = (cnt == SNT) ? SNT : cnt_t'(cnt - 2'd1);
    return nxt;
  endfunction

endpackage

// File: rtl/bpu_table.sv
// rtl/bpu_table.sv - BTB/BHT storage: one async read port, one op-based sync write port
module bpu_table
  import bpu_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
)(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [IDX_W-1:0]  rd_idx,
  output btb_entry_t        rd_entry,
  input  logic              wr_en,
  input  wr_op_t            wr_op,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [ADDR_W-1:0] wr_tag,
  input  logic [ADDR_W-1:0] wr_target,
  input  logic              wr_jmp
);

  logic              valid_q  [ENTRIES];
  cnt_t              cnt_q    [ENTRIES];
  logic              jmp_q    [ENTRIES];
  logic [ADDR_W-1:0] tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];

  // Async read returns the stored entry; a same-cycle write is not bypassed
  always_comb begin
    rd_entry.valid  = valid_q[rd_idx];
    rd_entry.jmp    = jmp_q[rd_idx];
    rd_entry.tag    = tag_q[rd_idx];
    rd_entry.target = target_q[rd_idx];
    rd_entry.cnt    = cnt_q[rd_idx];
  end

  // Valid bits and counters: cleared on reset, updated per write op
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= WNT;
      end
    end else if (wr_en) begin
      case (wr_op)
        WR_TAKEN: begin
          valid_q[wr_idx] <= 1'b1;
          cnt_q[wr_idx]   <= wr_jmp ? ST : sat_update(cnt_q[wr_idx], 1'b1);
        end
        WR_NOT_TAKEN: cnt_q[wr_idx] <= sat_update(cnt_q[wr_idx], 1'b0);
        WR_INVAL: begin
          if (valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag)) valid_q[wr_idx] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Payload fields only matter once valid, so they need no reset
  always_ff @(posedge clk) begin
    if (wr_en && (wr_op == WR_TAKEN)) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
      jmp_q[wr_idx]    <= wr_jmp;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - BTB predictor and EX-stage resolver; BPU_STATS_EN adds perf counters
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16
`ifdef BPU_STATS_EN
  , parameter int STAT_W = 32
`endif
)(
  input  logic            clk,
  input  logic            reset_n,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  output logic [31:0]     pred_next_pc,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [31:0]     ex_imm,
  input  logic [31:0]     ex_alu_result,
  input  logic            ex_branch,
  input  logic            ex_jal,
  input  logic            ex_jalr,
  input  logic            ex_halt,
  input  logic            ex_pred_taken,
  input  logic [31:0]     ex_pred_pc,
  output logic [31:0]     ex_pc_four,
  output logic            redirect,
  output logic [31:0]     redirect_pc
`ifdef BPU_STATS_EN
  , output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [31:0]      if_pc_ext, ex_pc_ext;
  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [31:0]      if_tag, ex_tag;
  btb_entry_t       rd_entry;
  logic             hit, ctrl, act_taken, mispred, upd, unused_pred;
  logic [31:0]      act_pc, next_pc;
  wr_op_t           wr_op;

  assign if_pc_ext   = 32'(if_pc);
  assign ex_pc_ext   = 32'(ex_pc);
  assign if_idx      = if_pc[IDX_W+1:2];
  assign ex_idx      = ex_pc[IDX_W+1:2];
  assign if_tag      = if_pc_ext >> (IDX_W + 2);
  assign ex_tag      = ex_pc_ext >> (IDX_W + 2);
  assign unused_pred = ex_pred_taken;

  // Fetch-side lookup: taken only on a tag hit with a jump or a taken-leaning counter
  always_comb begin
    hit          = rd_entry.valid && (rd_entry.tag == if_tag);
    pred_taken   = hit && (rd_entry.jmp || (rd_entry.cnt == WT) || (rd_entry.cnt == ST));
    pred_next_pc = pred_taken ? rd_entry.target : if_pc_ext + 32'd4;
  end

  // EX resolution: actual next PC, mispredict detection, redirect and table op
  always_comb begin
    ctrl        = ex_branch | ex_jal | ex_jalr;
    act_taken   = ex_jal | ex_jalr | (ex_branch & ex_alu_result[0]);
    act_pc      = ex_jalr ? {ex_alu_result[31:1], 1'b0} : ex_pc_ext + ex_imm;
    ex_pc_four  = ex_pc_ext + 32'd4;
    next_pc     = act_taken ? act_pc : ex_pc_four;
    mispred     = ex_valid & ~ex_halt & (ex_pred_pc != next_pc);
    redirect    = reset_n & (mispred | (ex_valid & ex_halt));
    redirect_pc = ex_halt ? ex_pc_ext : next_pc;
    upd         = ex_valid & ~ex_halt;
    if (act_taken)      wr_op = WR_TAKEN;
    else if (ex_branch) wr_op = WR_NOT_TAKEN;
    else                wr_op = WR_INVAL;
  end

  bpu_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_idx    (if_idx),
    .rd_entry  (rd_entry),
    .wr_en     (upd),
    .wr_op     (wr_op),
    .wr_idx    (ex_idx),
    .wr_tag    (ex_tag),
    .wr_target (32'(act_pc[PC_W-1:0])),
    .wr_jmp    (ex_jal | ex_jalr)
  );

`ifdef BPU_STATS_EN
  // Performance counters: resolved control transfers and non-halt redirects
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (upd) begin
      if (ctrl)    stat_branches <= stat_branches + STAT_W'(1);
      if (mispred) stat_mispred  <= stat_mispred + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - directed scoreboard bench for branch_predict_unit
module tb_branch_predict_unit;

  localparam int S_PT = 0, S_NPC = 1, S_RD = 2, S_RPC = 3, S_PC4 = 4, S_SB = 5, S_SM = 6;

  typedef struct {
    int          sel;
    logic [31:0] val;
    string       tag;
  } exp_t;

  logic        clk, reset_n;
  logic [8:0]  if_pc, ex_pc;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        ex_valid, ex_branch, ex_jal, ex_jalr, ex_halt, ex_pred_taken;
  logic [31:0] ex_imm, ex_alu_result, ex_pred_pc, ex_pc_four, redirect_pc;
  logic        redirect;
`ifdef BPU_STATS_EN
  logic [31:0] stat_branches, stat_mispred;
`endif

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  branch_predict_unit dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .if_pc         (if_pc),
    .pred_taken    (pred_taken),
    .pred_next_pc  (pred_next_pc),
    .ex_valid      (ex_valid),
    .ex_pc         (ex_pc),
    .ex_imm        (ex_imm),
    .ex_alu_result (ex_alu_result),
    .ex_branch     (ex_branch),
    .ex_jal        (ex_jal),
    .ex_jalr       (ex_jalr),
    .ex_halt       (ex_halt),
    .ex_pred_taken (ex_pred_taken),
    .ex_pred_pc    (ex_pred_pc),
    .ex_pc_four    (ex_pc_four),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc)
`ifdef BPU_STATS_EN
    , .stat_branches (stat_branches),
    .stat_mispred  (stat_mispred)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] obs(int sel);
    logic [31:0] v;
    case (sel)
      S_PT:    v = 32'(pred_taken);
      S_NPC:   v = pred_next_pc;
      S_RD:    v = 32'(redirect);
      S_RPC:   v = redirect_pc;
      S_PC4:   v = ex_pc_four;
`ifdef BPU_STATS_EN
      S_SB:    v = stat_branches;
      S_SM:    v = stat_mispred;
`endif
      default: v = 32'hDEAD_BEEF;
    endcase
    return v;
  endfunction

  task automatic expect_val(input int sel, input logic [31:0] val, input string tag);
    exp_t e;
    e.sel = sel;
    e.val = val;
    e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [31:0] o;
    #3;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = obs(e.sel);
      checks++;
      assert (o === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_drive(input logic v, input logic [8:0] pc, input logic [31:0] imm,
                          input logic [31:0] alu, input logic br, input logic jal,
                          input logic jalr, input logic halt, input logic pt,
                          input logic [31:0] ppc);
    ex_valid = v; ex_pc = pc; ex_imm = imm; ex_alu_result = alu;
    ex_branch = br; ex_jal = jal; ex_jalr = jalr; ex_halt = halt;
    ex_pred_taken = pt; ex_pred_pc = ppc;
  endtask

  task automatic ex_idle();
    ex_drive(1'b0, 9'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    // 1. reset: outputs forced quiet even with a halt in EX
    reset_n = 1'b0;
    if_pc   = 9'h010;
    ex_drive(1'b1, 9'h080, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    expect_val(S_PT, 32'h0, "rst_pred_taken");
    expect_val(S_NPC, 32'h14, "rst_pred_next_pc");
    expect_val(S_RD, 32'h0, "rst_redirect");
    expect_val(S_PC4, 32'h84, "rst_ex_pc_four");
`ifdef BPU_STATS_EN
    expect_val(S_SB, 32'h0, "rst_stat_branches");
    expect_val(S_SM, 32'h0, "rst_stat_mispred");
`endif
    check();
    tick();
    tick();
    reset_n = 1'b1;
    ex_idle();

    // 2. BEQ at 0x010 taken, first time unpredicted; same-cycle lookup sees old entry
    ex_drive(1'b1, 9'h010, 32'h20, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h14);
    expect_val(S_RD, 32'h1, "beq1_redirect");
    expect_val(S_RPC, 32'h30, "beq1_redirect_pc");
    expect_val(S_PC4, 32'h14, "beq1_ex_pc_four");
    expect_val(S_PT, 32'h0, "beq1_no_bypass");
    check();
    tick();
    ex_idle();
    expect_val(S_PT, 32'h1, "beq1_pred_taken");
    expect_val(S_NPC, 32'h30, "beq1_pred_next_pc");
    expect_val(S_RD, 32'h0, "idle_redirect");
    check();
    ex_drive(1'b1, 9'h010, 32'h20, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h30);
    expect_val(S_RD, 32'h0, "beq2_redirect");
    check();
    tick();

    // 3. two more taken (4 total) must saturate, then not-taken twice
    for (int i = 0; i < 2; i++) begin
      ex_drive(1'b1, 9'h010, 32'h20, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h30);
      expect_val(S_RD, 32'h0, "beq_more_redirect");
      check();
      tick();
    end
    ex_idle();
    expect_val(S_PT, 32'h1, "sat_st_pred_taken");
    check();
    ex_drive(1'b1, 9'h010, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h30);
    expect_val(S_RD, 32'h1, "nt1_redirect");
    expect_val(S_RPC, 32'h14, "nt1_redirect_pc");
    check();
    tick();
    ex_idle();
    expect_val(S_PT, 32'h1, "nt1_still_taken");
    expect_val(S_NPC, 32'h30, "nt1_pred_next_pc");
    check();
    ex_drive(1'b1, 9'h010, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h30);
    expect_val(S_RD, 32'h1, "nt2_redirect");
    check();
    tick();
    ex_idle();
    expect_val(S_PT, 32'h0, "nt2_pred_taken");
    expect_val(S_NPC, 32'h14, "nt2_pred_next_pc");
    check();

    // 4. JALR at 0x040, target LSB cleared
    ex_drive(1'b1, 9'h040, 32'h0, 32'h0FF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h44);
    expect_val(S_RD, 32'h1, "jalr_redirect");
    expect_val(S_RPC, 32'hFE, "jalr_redirect_pc");
    expect_val(S_PC4, 32'h44, "jalr_ex_pc_four");
    check();
    tick();
    ex_idle();
    if_pc = 9'h040;
    expect_val(S_PT, 32'h1, "jalr_pred_taken");
    expect_val(S_NPC, 32'hFE, "jalr_pred_next_pc");
    check();

    // 5. halt: self redirect, no table write even with branch fields set
    ex_drive(1'b1, 9'h080, 32'h20, 32'h1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    expect_val(S_RD, 32'h1, "halt_redirect");
    expect_val(S_RPC, 32'h80, "halt_redirect_pc");
    check();
    tick();
    ex_idle();
    if_pc = 9'h080;
    expect_val(S_PT, 32'h0, "halt_no_alloc");
    expect_val(S_NPC, 32'h84, "halt_pred_next_pc");
    check();
    if_pc = 9'h040;
    expect_val(S_PT, 32'h1, "halt_kept_jalr");
    check();

    // 6. JAL at 0x050 -> 0x100, then an aliased ADD invalidates it
    ex_drive(1'b1, 9'h050, 32'hB0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h54);
    expect_val(S_RD, 32'h1, "jal_redirect");
    expect_val(S_RPC, 32'h100, "jal_redirect_pc");
    expect_val(S_PC4, 32'h54, "jal_ex_pc_four");
    check();
    tick();
    ex_idle();
    if_pc = 9'h050;
    expect_val(S_PT, 32'h1, "jal_pred_taken");
    expect_val(S_NPC, 32'h100, "jal_pred_next_pc");
    check();
    if_pc = 9'h010;
    expect_val(S_PT, 32'h0, "jal_evicted_beq");
    expect_val(S_NPC, 32'h14, "jal_evicted_npc");
    check();
    ex_drive(1'b1, 9'h050, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
    expect_val(S_RD, 32'h1, "alias_redirect");
    expect_val(S_RPC, 32'h54, "alias_redirect_pc");
    check();
    tick();
    ex_idle();
    if_pc = 9'h050;
    expect_val(S_PT, 32'h0, "alias_invalidated");
    expect_val(S_NPC, 32'h54, "alias_pred_next_pc");
    check();
    ex_drive(1'b1, 9'h000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4);
    expect_val(S_RD, 32'h0, "add_other_tag_redirect");
    check();
    tick();
    ex_idle();
    if_pc = 9'h040;
    expect_val(S_PT, 32'h1, "add_other_tag_kept");
    check();
`ifdef BPU_STATS_EN
    expect_val(S_SB, 32'd8, "stat_branches");
    expect_val(S_SM, 32'd6, "stat_mispred");
    check();
`endif

    // reset during an update: write lost, tables cleared
    ex_drive(1'b1, 9'h050, 32'hB0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h54);
    reset_n = 1'b0;
    expect_val(S_RD, 32'h0, "rst_mid_redirect");
    check();
    tick();
    reset_n = 1'b1;
    ex_idle();
    if_pc = 9'h050;
    expect_val(S_PT, 32'h0, "rst_mid_write_lost");
    check();
    if_pc = 9'h040;
    expect_val(S_PT, 32'h0, "rst_mid_cleared");
    expect_val(S_NPC, 32'h44, "rst_mid_npc");
    check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
